seg_display_decoder: RTL and testbench

Passive receiver for the active-low 7-segment display bus (seg_n cathodes, an_n anodes) produced by the board's display FSMs. It samples the bus, waits for each digit pattern to hold stable, decodes it back to a hex nibble per anode position, and flags illegal patterns. It also checks that digit 0 (the rightmost digit) follows the 1 -> 7 -> 0 -> 1 display sequence. It sits beside the display driver as an on-chip self-check and monitor. Its status can be read by the MCU or shown on LEDs.

---
 rtl/seg_display_decoder.sv | 198 +++++++++++++++++++
 tb/tb_seg_display_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_decoder.sv
// seg_display_decoder: passive monitor for the active-low 7-segment bus.
// Waits for each {an_n, seg_n} sample to hold steady, decodes it to a hex nibble
// per anode position, flags illegal patterns, and checks that digit 0 walks the
// 1 -> 7 -> 0 -> 1 display sequence.
module seg_display_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digit_val,
  output logic [3:0]  digit_valid,
  output logic        upd_pulse,
  output logic [1:0]  upd_idx,
  output logic        bad_pulse,
  output logic        bad_sticky,
  output logic [1:0]  seq_state,
  output logic        seq_err,
  output logic [7:0]  err_count,
  output logic [7:0]  loop_count
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    EXP7 = 2'd1,
    EXP0 = 2'd2,
    EXP1 = 2'd3
  } seq_t;

  // Returns {legal, nibble} for an active-low a..g pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0000100: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b1100000: return {1'b1, 4'hB};
      7'b0110001: return {1'b1, 4'hC};
      7'b1000010: return {1'b1, 4'hD};
      7'b0110000: return {1'b1, 4'hE};
      7'b0111000: return {1'b1, 4'hF};
      default:    return 5'b0_0000;
    endcase
  endfunction

  // Returns {exactly_one_low, index} for the active-low anode vector.
  function automatic logic [2:0] decode_an(input logic [3:0] a);
    case (a)
      4'b1110: return {1'b1, 2'd0};
      4'b1101: return {1'b1, 2'd1};
      4'b1011: return {1'b1, 2'd2};
      4'b0111: return {1'b1, 2'd3};
      default: return 3'b000;
    endcase
  endfunction

  logic [10:0] s_cur;
  logic [7:0]  stab_cnt;
  logic [10:0] bus_now;
  logic        changed;
  logic        accept;
  logic [2:0]  an_dec;
  logic [4:0]  seg_dec;
  logic        is_blank;
  logic        acc_ok;
  logic [1:0]  acc_idx;
  logic [3:0]  acc_nib;
  logic        last0_valid;
  logic [3:0]  last0_val;
  logic        seq_in;
  seq_t        state;

  // Comparing the incoming sample against s_cur is the same as comparing the
  // next s_cur against the next s_prev, so the count lines up with the sample
  // register without keeping a separate s_prev copy.
  assign bus_now  = {an_n, seg_n};
  assign changed  = (bus_now != s_cur);
  assign accept   = !changed && (stab_cnt == STAB_PRE);
  assign an_dec   = decode_an(s_cur[10:7]);
  assign seg_dec  = decode_seg(s_cur[6:0]);
  assign is_blank = (s_cur[6:0] == 7'b1111111);
  assign acc_ok   = accept && an_dec[2];
  assign acc_idx  = an_dec[1:0];
  assign acc_nib  = seg_dec[3:0];
  assign seq_in   = acc_ok && (acc_idx == 2'd0) && seg_dec[4] &&
                    (!last0_valid || (acc_nib != last0_val));
  assign seq_state = state;

  // Sample the bus and count how long it has held the same value.
  always_ff @(posedge clk) begin
    if (RST) begin
      s_cur    <= '1;
      stab_cnt <= 8'd0;
    end else begin
      s_cur <= bus_now;
      if (changed)
        stab_cnt <= 8'd1;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // On each accept, update the addressed digit and raise the strobes.
  always_ff @(posedge clk) begin
    if (RST) begin
      digit_val   <= 16'h0000;
      digit_valid <= 4'b0000;
      upd_pulse   <= 1'b0;
      upd_idx     <= 2'd0;
      bad_pulse   <= 1'b0;
      bad_sticky  <= 1'b0;
    end else begin
      upd_pulse <= acc_ok;
      bad_pulse <= 1'b0;
      if (acc_ok) begin
        upd_idx <= acc_idx;
        if (seg_dec[4]) begin
          digit_val[{acc_idx, 2'b00} +: 4] <= acc_nib;
          digit_valid[acc_idx]             <= 1'b1;
        end else if (is_blank) begin
          digit_valid[acc_idx] <= 1'b0;
        end else begin
          digit_valid[acc_idx] <= 1'b0;
          bad_pulse            <= 1'b1;
          bad_sticky           <= 1'b1;
        end
      end
    end
  end

  // Track digit 0 through the 1 -> 7 -> 0 -> 1 loop; held repeats are filtered.
  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= SYNC;
      seq_err     <= 1'b0;
      err_count   <= 8'd0;
      loop_count  <= 8'd0;
      last0_valid <= 1'b0;
      last0_val   <= 4'h0;
    end else begin
      seq_err <= 1'b0;
      if (seq_in) begin
        last0_valid <= 1'b1;
        last0_val   <= acc_nib;
        case (state)
          SYNC: begin
            if (acc_nib == 4'h1)
              state <= EXP7;
          end
          EXP7: begin
            if (acc_nib == 4'h7) begin
              state <= EXP0;
            end else begin
              seq_err <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              state <= (acc_nib == 4'h1) ? EXP7 : SYNC;
            end
          end
          EXP0: begin
            if (acc_nib == 4'h0) begin
              state      <= EXP1;
              loop_count <= loop_count + 8'd1;
            end else begin
              seq_err <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              state <= (acc_nib == 4'h1) ? EXP7 : SYNC;
            end
          end
          EXP1: begin
            if (acc_nib == 4'h1) begin
              state <= EXP7;
            end else begin
              seq_err <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              state <= SYNC;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_display_decoder.sv
// tb_seg_display_decoder: directed checks of the 7-segment bus monitor with
// hand-computed expected values.
module tb_seg_display_decoder;

  logic        clk = 1'b0;
  logic        RST;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digit_val;
  logic [3:0]  digit_valid;
  logic        upd_pulse;
  logic [1:0]  upd_idx;
  logic        bad_pulse;
  logic        bad_sticky;
  logic [1:0]  seq_state;
  logic        seq_err;
  logic [7:0]  err_count;
  logic [7:0]  loop_count;

  seg_display_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .RST         (RST),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digit_val   (digit_val),
    .digit_valid (digit_valid),
    .upd_pulse   (upd_pulse),
    .upd_idx     (upd_idx),
    .bad_pulse   (bad_pulse),
    .bad_sticky  (bad_sticky),
    .seq_state   (seq_state),
    .seq_err     (seq_err),
    .err_count   (err_count),
    .loop_count  (loop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int upd_cnt;
  int bad_cnt;
  int serr_cnt;
  int serr_sum;
  int misalign = 0;
  logic [1:0] last_idx;
  logic [6:0] pat [16];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus value for n clock edges and tally the strobes seen.
  task automatic apply_stimulus(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n     = an;
    seg_n    = seg;
    upd_cnt  = 0;
    bad_cnt  = 0;
    serr_cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (upd_pulse) begin
        upd_cnt++;
        last_idx = upd_idx;
      end
      if (bad_pulse) bad_cnt++;
      if (seq_err) begin
        serr_cnt++;
        if (!upd_pulse) misalign++;
      end
    end
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    an_n  = 4'b1110;
    seg_n = 7'b1001111;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_output("rst_no_upd", {31'd0, upd_pulse}, 32'd0);
    end
    RST = 1'b0;
  endtask

  initial begin
    pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
    pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0000100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
    pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;
    RST   = 1'b1;
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    last_idx = 2'd0;

    // Reset state with an active bus
    do_reset();
    check_output("rst_digit_val",   {16'd0, digit_val}, 32'd0);
    check_output("rst_digit_valid", {28'd0, digit_valid}, 32'd0);
    check_output("rst_bad",         {31'd0, bad_pulse}, 32'd0);
    check_output("rst_sticky",      {31'd0, bad_sticky}, 32'd0);
    check_output("rst_seq_state",   {30'd0, seq_state}, 32'd0);
    check_output("rst_seq_err",     {31'd0, seq_err}, 32'd0);
    check_output("rst_err_count",   {24'd0, err_count}, 32'd0);
    check_output("rst_loop_count",  {24'd0, loop_count}, 32'd0);

    // Decode sweep on digit 0
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(4'b1110, pat[i], 10);
      check_output($sformatf("sweep%0d_upd", i), upd_cnt, 32'd1);
      check_output($sformatf("sweep%0d_val", i), {28'd0, digit_val[3:0]}, i);
      check_output($sformatf("sweep%0d_valid", i), {31'd0, digit_valid[0]}, 32'd1);
    end
    apply_stimulus(4'b1110, 7'b1111110, 10);
    check_output("illegal_upd",    upd_cnt, 32'd1);
    check_output("illegal_bad",    bad_cnt, 32'd1);
    check_output("illegal_sticky", {31'd0, bad_sticky}, 32'd1);
    check_output("illegal_valid",  {31'd0, digit_valid[0]}, 32'd0);
    apply_stimulus(4'b1110, 7'b1111111, 10);
    check_output("blank_upd",    upd_cnt, 32'd1);
    check_output("blank_bad",    bad_cnt, 32'd0);
    check_output("blank_valid",  {31'd0, digit_valid[0]}, 32'd0);
    check_output("blank_sticky", {31'd0, bad_sticky}, 32'd1);

    // Glitch rejection and anode qualification
    do_reset();
    apply_stimulus(4'b1110, pat[7], 3);
    check_output("glitch7_upd", upd_cnt, 32'd0);
    apply_stimulus(4'b1110, pat[0], 6);
    check_output("glitch0_upd",   upd_cnt, 32'd1);
    check_output("glitch0_val",   {28'd0, digit_val[3:0]}, 32'd0);
    check_output("glitch0_valid", {31'd0, digit_valid[0]}, 32'd1);
    apply_stimulus(4'b1100, pat[5], 10);
    check_output("multi_an_upd", upd_cnt, 32'd0);

    // Sequence pass: 1 (two windows), 7, 0, 1, 7, 0
    do_reset();
    serr_sum = 0;
    apply_stimulus(4'b1110, pat[1], 16); serr_sum += serr_cnt;
    check_output("pass_held1_upd", upd_cnt, 32'd1);
    apply_stimulus(4'b1110, pat[7], 8);  serr_sum += serr_cnt;
    apply_stimulus(4'b1110, pat[0], 8);  serr_sum += serr_cnt;
    check_output("pass_loop1", {24'd0, loop_count}, 32'd1);
    apply_stimulus(4'b1110, pat[1], 8);  serr_sum += serr_cnt;
    apply_stimulus(4'b1110, pat[7], 8);  serr_sum += serr_cnt;
    check_output("pass_state_exp0", {30'd0, seq_state}, 32'd2);
    apply_stimulus(4'b1110, pat[0], 8);  serr_sum += serr_cnt;
    check_output("pass_seq_err",  serr_sum, 32'd0);
    check_output("pass_loop2",    {24'd0, loop_count}, 32'd2);
    check_output("pass_state",    {30'd0, seq_state}, 32'd3);
    check_output("pass_errcount", {24'd0, err_count}, 32'd0);

    // Sequence error: 1, 7, 1, 0
    do_reset();
    apply_stimulus(4'b1110, pat[1], 8);
    apply_stimulus(4'b1110, pat[7], 8);
    check_output("err_pre_state", {30'd0, seq_state}, 32'd2);
    apply_stimulus(4'b1110, pat[1], 8);
    check_output("err1_pulse", serr_cnt, 32'd1);
    check_output("err1_count", {24'd0, err_count}, 32'd1);
    check_output("err1_state", {30'd0, seq_state}, 32'd1);
    apply_stimulus(4'b1110, pat[0], 8);
    check_output("err2_pulse", serr_cnt, 32'd1);
    check_output("err2_count", {24'd0, err_count}, 32'd2);
    check_output("err2_state", {30'd0, seq_state}, 32'd0);
    check_output("err2_loop",  {24'd0, loop_count}, 32'd0);

    // Multiplexed digits 3, 2, 1, 0
    do_reset();
    apply_stimulus(4'b0111, pat[3], 8);
    check_output("mux_idx3", {30'd0, last_idx}, 32'd3);
    apply_stimulus(4'b1011, pat[2], 8);
    check_output("mux_idx2", {30'd0, last_idx}, 32'd2);
    apply_stimulus(4'b1101, pat[1], 8);
    check_output("mux_idx1", {30'd0, last_idx}, 32'd1);
    apply_stimulus(4'b1110, pat[0], 8);
    check_output("mux_idx0",   {30'd0, last_idx}, 32'd0);
    check_output("mux_val",    {16'd0, digit_val}, 32'h3210);
    check_output("mux_valid",  {28'd0, digit_valid}, 32'hF);

    // Reset two cycles into a stable window restarts the count
    apply_stimulus(4'b1110, pat[5], 2);
    check_output("midrst_pre_upd", upd_cnt, 32'd0);
    RST = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_rst_upd",   {31'd0, upd_pulse}, 32'd0);
    check_output("midrst_rst_valid", {28'd0, digit_valid}, 32'd0);
    RST = 1'b0;
    apply_stimulus(4'b1110, pat[5], 3);
    check_output("midrst_early_upd", upd_cnt, 32'd0);
    apply_stimulus(4'b1110, pat[5], 1);
    check_output("midrst_upd", upd_cnt, 32'd1);
    check_output("midrst_val", {28'd0, digit_val[3:0]}, 32'd5);

    check_output("seq_err_with_upd", misalign, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
